// File: rtl/rggen_backdoor_seq_pkg.sv
// Shared types for the per-register backdoor sequencer: FSM states and the
// latched request / pending response records.
package rggen_backdoor_seq_pkg;

    localparam int BACKDOOR_DATA_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ARB     = 3'd1,
        WRITE   = 3'd2,
        SAMPLE  = 3'd3,
        RESPOND = 3'd4
    } rggen_backdoor_seq_state_e;

    typedef struct packed {
        logic                           write;
        logic [BACKDOOR_DATA_WIDTH-1:0] mask;
        logic [BACKDOOR_DATA_WIDTH-1:0] data;
    } rggen_backdoor_seq_request_t;

    typedef struct packed {
        logic                           error;
        logic [BACKDOOR_DATA_WIDTH-1:0] data;
    } rggen_backdoor_seq_response_t;

    // Frontdoor is held off while the register is being written or sampled.
    function automatic logic state_locks_frontdoor(rggen_backdoor_seq_state_e state);
        return (state == WRITE) || (state == SAMPLE);
    endfunction

endpackage

// File: rtl/rggen_backdoor_wait_timer.sv
// Counts consecutive frontdoor-busy cycles seen in arbitration and flags when
// the wait budget is used up. A zero limit means wait forever.
module rggen_backdoor_wait_timer #(
    parameter int WAIT_LIMIT         = 16,
    parameter int WAIT_COUNTER_WIDTH = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_expired
);

    logic [WAIT_COUNTER_WIDTH-1:0] count_q;
    logic [WAIT_COUNTER_WIDTH-1:0] count_d;

    // Next count: clear wins, otherwise saturating increment.
    always_comb begin
        count_d = count_q;
        if (i_clear) begin
            count_d = {WAIT_COUNTER_WIDTH{1'b0}};
        end else if (i_count_en && (count_q != {WAIT_COUNTER_WIDTH{1'b1}})) begin
            count_d = count_q + WAIT_COUNTER_WIDTH'(1);
        end else begin
            count_d = count_q;
        end
    end

    // Counter register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            count_q <= {WAIT_COUNTER_WIDTH{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    generate
        if (WAIT_LIMIT == 0) begin : g_no_limit
            assign o_expired = 1'b0;
        end else begin : g_limit
            assign o_expired = (count_q == WAIT_COUNTER_WIDTH'(WAIT_LIMIT - 1));
        end
    endgenerate

endmodule

// File: rtl/rggen_backdoor_sequencer.sv
// Sequences one backdoor read/write at a time against a register's storage:
// arbitrate with frontdoor, strobe a masked write, sample, then respond.
module rggen_backdoor_sequencer
    import rggen_backdoor_seq_pkg::*;
#(
    parameter int DATA_WIDTH         = BACKDOOR_DATA_WIDTH,
    parameter int WAIT_LIMIT         = 16,
    parameter int WAIT_COUNTER_WIDTH = (WAIT_LIMIT > 0) ? $clog2(WAIT_LIMIT + 1) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_backdoor_valid,
    output logic                  o_backdoor_ready,
    input  logic                  i_backdoor_write,
    input  logic [DATA_WIDTH-1:0] i_backdoor_mask,
    input  logic [DATA_WIDTH-1:0] i_backdoor_data,
    output logic                  o_backdoor_rsp_valid,
    input  logic                  i_backdoor_rsp_ready,
    output logic                  o_backdoor_rsp_error,
    output logic [DATA_WIDTH-1:0] o_backdoor_rsp_data,
    input  logic                  i_frontdoor_busy,
    output logic                  o_backdoor_lock,
    output logic                  o_reg_write_valid,
    output logic [DATA_WIDTH-1:0] o_reg_write_mask,
    output logic [DATA_WIDTH-1:0] o_reg_write_data,
    input  logic [DATA_WIDTH-1:0] i_reg_value
);

    rggen_backdoor_seq_state_e    state_q;
    rggen_backdoor_seq_state_e    state_d;
    rggen_backdoor_seq_request_t  req_q;
    rggen_backdoor_seq_request_t  req_d;
    rggen_backdoor_seq_response_t rsp_q;
    rggen_backdoor_seq_response_t rsp_d;

    logic                  ready_q;
    logic                  ready_d;
    logic                  rsp_valid_q;
    logic                  rsp_valid_d;
    logic                  lock_q;
    logic                  lock_d;
    logic                  wr_valid_q;
    logic                  wr_valid_d;
    logic [DATA_WIDTH-1:0] wr_mask_q;
    logic [DATA_WIDTH-1:0] wr_mask_d;
    logic [DATA_WIDTH-1:0] wr_data_q;
    logic [DATA_WIDTH-1:0] wr_data_d;

    logic timer_clear_s;
    logic timer_count_en_s;
    logic timer_expired_s;

    rggen_backdoor_wait_timer #(
        .WAIT_LIMIT         (WAIT_LIMIT),
        .WAIT_COUNTER_WIDTH (WAIT_COUNTER_WIDTH)
    ) u_wait_timer (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (timer_clear_s),
        .i_count_en (timer_count_en_s),
        .o_expired  (timer_expired_s)
    );

    // Sequencer state transitions, request latch and response capture.
    always_comb begin
        state_d          = state_q;
        req_d            = req_q;
        rsp_d            = rsp_q;
        timer_clear_s    = 1'b0;
        timer_count_en_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_backdoor_valid) begin
                    req_d.write   = i_backdoor_write;
                    req_d.mask    = BACKDOOR_DATA_WIDTH'(i_backdoor_mask);
                    req_d.data    = BACKDOOR_DATA_WIDTH'(i_backdoor_data);
                    timer_clear_s = 1'b1;
                    state_d       = ARB;
                end else begin
                    state_d = IDLE;
                end
            end
            ARB: begin
                if (!i_frontdoor_busy) begin
                    state_d = req_q.write ? WRITE : SAMPLE;
                end else if (timer_expired_s) begin
                    // Timed out: report an error without touching the register.
                    rsp_d.error = 1'b1;
                    rsp_d.data  = {BACKDOOR_DATA_WIDTH{1'b0}};
                    state_d     = RESPOND;
                end else begin
                    timer_count_en_s = 1'b1;
                    state_d          = ARB;
                end
            end
            WRITE: begin
                state_d = SAMPLE;
            end
            SAMPLE: begin
                rsp_d.error = 1'b0;
                rsp_d.data  = BACKDOOR_DATA_WIDTH'(i_reg_value);
                state_d     = RESPOND;
            end
            RESPOND: begin
                if (i_backdoor_rsp_ready) begin
                    rsp_d   = '{error: 1'b0, data: {BACKDOOR_DATA_WIDTH{1'b0}}};
                    state_d = IDLE;
                end else begin
                    state_d = RESPOND;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output values for the upcoming state, so every output leaves a flop.
    always_comb begin
        ready_d     = (state_d == IDLE);
        rsp_valid_d = (state_d == RESPOND);
        lock_d      = state_locks_frontdoor(state_d);
        wr_valid_d  = (state_d == WRITE);
        if (wr_valid_d) begin
            wr_mask_d = DATA_WIDTH'(req_d.mask);
            wr_data_d = DATA_WIDTH'(req_d.data);
        end else begin
            wr_mask_d = {DATA_WIDTH{1'b0}};
            wr_data_d = {DATA_WIDTH{1'b0}};
        end
    end

    // State, latch and output registers; reset drops any in-flight work.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            req_q       <= '{write: 1'b0, mask: {BACKDOOR_DATA_WIDTH{1'b0}}, data: {BACKDOOR_DATA_WIDTH{1'b0}}};
            rsp_q       <= '{error: 1'b0, data: {BACKDOOR_DATA_WIDTH{1'b0}}};
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            lock_q      <= 1'b0;
            wr_valid_q  <= 1'b0;
            wr_mask_q   <= {DATA_WIDTH{1'b0}};
            wr_data_q   <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            rsp_q       <= rsp_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            lock_q      <= lock_d;
            wr_valid_q  <= wr_valid_d;
            wr_mask_q   <= wr_mask_d;
            wr_data_q   <= wr_data_d;
        end
    end

    assign o_backdoor_ready     = ready_q;
    assign o_backdoor_rsp_valid = rsp_valid_q;
    assign o_backdoor_rsp_error = rsp_q.error;
    assign o_backdoor_rsp_data  = DATA_WIDTH'(rsp_q.data);
    assign o_backdoor_lock      = lock_q;
    assign o_reg_write_valid    = wr_valid_q;
    assign o_reg_write_mask     = wr_mask_q;
    assign o_reg_write_data     = wr_data_q;

endmodule

// File: tb/tb_rggen_backdoor_sequencer.sv
// Bench for rggen_backdoor_sequencer: directed vector table, randomized
// transactions against a transaction-level model, timeout and reset cases.
module tb_rggen_backdoor_sequencer;

    localparam int LIM = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic        write;
    logic [31:0] mask;
    logic [31:0] data;
    logic        rsp_ready;
    logic        busy;
    logic [31:0] reg_value;

    logic        ready, rsp_valid, rsp_error, lock, wv;
    logic [31:0] rsp_data, wm, wd;
    logic        w4_ready, w4_rsp_valid, w4_rsp_error, w4_lock, w4_wv;
    logic [31:0] w4_rsp_data, w4_wm, w4_wd;
    logic        w0_ready, w0_rsp_valid, w0_rsp_error, w0_lock, w0_wv;
    logic [31:0] w0_rsp_data, w0_wm, w0_wd;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] reg_model;

    typedef struct {
        logic        wr;
        logic [31:0] mask;
        logic [31:0] data;
        logic [31:0] reg_init;
        int          nbusy;
        int          rdelay;
        logic [31:0] exp_data;
        logic        exp_err;
        int          rsp_t;
    } vec_t;

    vec_t vecs[7];

    always #5 clk = ~clk;

    rggen_backdoor_sequencer #(.DATA_WIDTH(32), .WAIT_LIMIT(LIM)) dut (
        .i_clk(clk), .i_rst(rst), .i_backdoor_valid(valid), .o_backdoor_ready(ready),
        .i_backdoor_write(write), .i_backdoor_mask(mask), .i_backdoor_data(data),
        .o_backdoor_rsp_valid(rsp_valid), .i_backdoor_rsp_ready(rsp_ready),
        .o_backdoor_rsp_error(rsp_error), .o_backdoor_rsp_data(rsp_data),
        .i_frontdoor_busy(busy), .o_backdoor_lock(lock), .o_reg_write_valid(wv),
        .o_reg_write_mask(wm), .o_reg_write_data(wd), .i_reg_value(reg_value)
    );

    rggen_backdoor_sequencer #(.DATA_WIDTH(32), .WAIT_LIMIT(4)) dut_w4 (
        .i_clk(clk), .i_rst(rst), .i_backdoor_valid(valid), .o_backdoor_ready(w4_ready),
        .i_backdoor_write(write), .i_backdoor_mask(mask), .i_backdoor_data(data),
        .o_backdoor_rsp_valid(w4_rsp_valid), .i_backdoor_rsp_ready(rsp_ready),
        .o_backdoor_rsp_error(w4_rsp_error), .o_backdoor_rsp_data(w4_rsp_data),
        .i_frontdoor_busy(busy), .o_backdoor_lock(w4_lock), .o_reg_write_valid(w4_wv),
        .o_reg_write_mask(w4_wm), .o_reg_write_data(w4_wd), .i_reg_value(reg_value)
    );

    rggen_backdoor_sequencer #(.DATA_WIDTH(32), .WAIT_LIMIT(0)) dut_w0 (
        .i_clk(clk), .i_rst(rst), .i_backdoor_valid(valid), .o_backdoor_ready(w0_ready),
        .i_backdoor_write(write), .i_backdoor_mask(mask), .i_backdoor_data(data),
        .o_backdoor_rsp_valid(w0_rsp_valid), .i_backdoor_rsp_ready(rsp_ready),
        .o_backdoor_rsp_error(w0_rsp_error), .o_backdoor_rsp_data(w0_rsp_data),
        .i_frontdoor_busy(busy), .o_backdoor_lock(w0_lock), .o_reg_write_valid(w0_wv),
        .o_reg_write_mask(w0_wm), .o_reg_write_data(w0_wd), .i_reg_value(reg_value)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        valid     = 1'b0;
        write     = 1'b0;
        mask      = 32'h0;
        data      = 32'h0;
        busy      = 1'b0;
        rsp_ready = 1'b0;
        reg_value = reg_model;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // One request accepted in cycle 0; the frontdoor is busy for the first
    // nbusy arbitration cycles and the response is held off for rdelay cycles.
    task automatic run_txn(input logic wr, input logic [31:0] m, input logic [31:0] d,
                           input int nbusy, input int rdelay, input logic [31:0] exp_data,
                           input logic exp_err, input int rsp_t);
        int end_t;
        int strobe_t;
        logic in_rsp;
        end_t    = rsp_t + rdelay;
        strobe_t = (wr && !exp_err) ? rsp_t - 2 : -1;
        for (int c = 0; c <= end_t; c++) begin
            valid = (c == 0) ? 1'b1 : 1'($urandom_range(1));
            write = (c == 0) ? wr : 1'($urandom_range(1));
            mask  = (c == 0) ? m : $urandom();
            data  = (c == 0) ? d : $urandom();
            if (exp_err && c >= 1 && c <= LIM)
                busy = 1'b1;
            else if (!exp_err && c >= 1 && c <= nbusy)
                busy = 1'b1;
            else if (!exp_err && c == nbusy + 1)
                busy = 1'b0;
            else
                busy = 1'($urandom_range(1));
            if (c < rsp_t)
                rsp_ready = 1'($urandom_range(1));
            else
                rsp_ready = (c == end_t);
            reg_value = reg_model;
            #1;
            in_rsp = (c >= rsp_t) && (c <= end_t);
            check("ready", c, ready, c == 0);
            check("rsp_valid", c, rsp_valid, in_rsp);
            check("lock", c, lock, !exp_err && c >= nbusy + 2 && c < rsp_t);
            check("wr_strobe", c, wv, c == strobe_t);
            check("wr_mask", c, wm, (c == strobe_t) ? m : 32'h0);
            check("wr_data", c, wd, (c == strobe_t) ? d : 32'h0);
            if (in_rsp) begin
                check("rsp_data", c, rsp_data, exp_data);
                check("rsp_error", c, rsp_error, exp_err);
            end
            tick();
            if (c == strobe_t)
                reg_model = (reg_model & ~m) | (d & m);
        end
        valid = 1'b0;
    endtask

    initial begin
        logic        r_wr;
        logic        r_to;
        logic [31:0] r_m, r_d, r_exp;
        int          r_nb, r_rd, r_rt;
        int          w4_rsp_t;
        int          w0_rsp_seen;
        int          strobes;

        vecs[0] = '{1'b0, 32'h00000000, 32'h00000000, 32'hDEADBEEF, 0,  0, 32'hDEADBEEF, 1'b0, 3};
        vecs[1] = '{1'b1, 32'h0000FFFF, 32'h12345678, 32'hAAAAAAAA, 0,  0, 32'hAAAA5678, 1'b0, 4};
        vecs[2] = '{1'b0, 32'h00000000, 32'h00000000, 32'h0BADF00D, 5,  0, 32'h0BADF00D, 1'b0, 8};
        vecs[3] = '{1'b1, 32'hFFFFFFFF, 32'h00000001, 32'h00000055, 20, 1, 32'h00000000, 1'b1, 17};
        vecs[4] = '{1'b1, 32'h00000000, 32'hFFFFFFFF, 32'h13572468, 0,  0, 32'h13572468, 1'b0, 4};
        vecs[5] = '{1'b0, 32'h00000000, 32'h00000000, 32'hCAFEF00D, 0,  3, 32'hCAFEF00D, 1'b0, 3};
        vecs[6] = '{1'b1, 32'hFFFF0000, 32'hBEEF0000, 32'h12345678, 15, 2, 32'hBEEF5678, 1'b0, 19};

        reg_model = 32'h0;
        do_reset();
        #1;
        check("reset_ready", 0, ready, 1'b1);
        check("reset_rsp_valid", 0, rsp_valid, 1'b0);
        check("reset_rsp_error", 0, rsp_error, 1'b0);
        check("reset_rsp_data", 0, rsp_data, 32'h0);
        check("reset_lock", 0, lock, 1'b0);
        check("reset_strobe", 0, wv, 1'b0);
        check("reset_mask", 0, wm, 32'h0);
        check("reset_data", 0, wd, 32'h0);

        for (int i = 0; i < 7; i++) begin
            reg_model = vecs[i].reg_init;
            run_txn(vecs[i].wr, vecs[i].mask, vecs[i].data, vecs[i].nbusy, vecs[i].rdelay,
                    vecs[i].exp_data, vecs[i].exp_err, vecs[i].rsp_t);
        end

        // Random back-to-back traffic; expectations follow from the request alone.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(3) == 0)
                reg_model = $urandom();
            r_wr = 1'($urandom_range(1));
            case ($urandom_range(3))
                0:       r_m = 32'h0;
                1:       r_m = 32'hFFFFFFFF;
                default: r_m = $urandom();
            endcase
            r_d  = $urandom();
            r_nb = ($urandom_range(3) == 0) ? int'($urandom_range(20)) : int'($urandom_range(3));
            r_rd = int'($urandom_range(3));
            r_to = (r_nb >= LIM);
            if (r_to)
                r_exp = 32'h0;
            else if (r_wr)
                r_exp = (reg_model & ~r_m) | (r_d & r_m);
            else
                r_exp = reg_model;
            r_rt = r_to ? LIM + 1 : r_nb + (r_wr ? 4 : 3);
            run_txn(r_wr, r_m, r_d, r_nb, r_rd, r_exp, r_to, r_rt);
        end

        // Frontdoor busy forever: limit 4 times out, limit 0 keeps waiting.
        do_reset();
        write       = 1'b1;
        mask        = 32'hFFFFFFFF;
        data        = 32'h00000001;
        busy        = 1'b1;
        rsp_ready   = 1'b0;
        w4_rsp_t    = -1;
        w0_rsp_seen = 0;
        strobes     = 0;
        for (int c = 0; c < 105; c++) begin
            valid = (c == 0);
            #1;
            if (w4_rsp_valid && w4_rsp_t < 0) begin
                w4_rsp_t = c;
                check("w4_rsp_error", c, w4_rsp_error, 1'b1);
                check("w4_rsp_data", c, w4_rsp_data, 32'h0);
            end
            if (w0_rsp_valid)
                w0_rsp_seen = 1;
            if (w4_wv || w0_wv)
                strobes++;
            tick();
        end
        check("w4_rsp_cycle", 0, w4_rsp_t, 5);
        check("w0_no_rsp", 0, w0_rsp_seen, 0);
        check("timeout_no_strobe", 0, strobes, 0);

        // Reset during arbitration (cycle 1) and during the write strobe (cycle 2).
        for (int rc = 1; rc <= 2; rc++) begin
            do_reset();
            write     = 1'b1;
            mask      = 32'h000000FF;
            data      = 32'h0000005A;
            busy      = 1'b0;
            rsp_ready = 1'b1;
            for (int c = 0; c <= rc; c++) begin
                valid = (c == 0);
                rst   = (c == rc);
                #1;
                check("rst_pre_strobe", c, wv, c == 2);
                tick();
            end
            rst   = 1'b0;
            valid = 1'b0;
            #1;
            check("rst_strobe", rc + 1, wv, 1'b0);
            check("rst_mask", rc + 1, wm, 32'h0);
            check("rst_wdata", rc + 1, wd, 32'h0);
            check("rst_ready", rc + 1, ready, 1'b1);
            check("rst_rsp_valid", rc + 1, rsp_valid, 1'b0);
            check("rst_lock", rc + 1, lock, 1'b0);
            check("rst_rsp_data", rc + 1, rsp_data, 32'h0);
            tick();
            check("rst_ready_next", rc + 2, ready, 1'b1);
            check("rst_strobe_next", rc + 2, wv, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
